// File: rtl/nand_needle_pkg.sv
// Shared types, constants and square-coordinate helpers for the NAND-needle core.
package nand_needle_pkg;

    localparam int unsigned PIECE_W = 4;
    localparam int unsigned SQ_W    = 6;
    localparam int unsigned RES_W   = 8;
    localparam int unsigned NUM_SQ  = 64;

    typedef logic [PIECE_W-1:0] piece_t;
    typedef logic [SQ_W-1:0]    sq_t;
    typedef logic [RES_W-1:0]   res_t;
    typedef piece_t [NUM_SQ-1:0] board_t;

    localparam piece_t EMPTY    = 4'd0;
    localparam res_t   RES_NONE = 8'hFF;

    // Column (file) of a square: index = rank*8 + file.
    function automatic logic [2:0] file_of(input sq_t sq);
        return sq[2:0];
    endfunction

    // Row (rank) of a square.
    function automatic logic [2:0] rank_of(input sq_t sq);
        return sq[5:3];
    endfunction

endpackage

// File: rtl/nand_needle_8bit_core_if.sv
// Move-input / scan-result bus between the front end and the NAND-needle core.
interface nand_needle_8bit_core_if;
    import nand_needle_pkg::*;

    logic        step;
    logic        player_move;
    sq_t         player_from;
    sq_t         player_to;
    logic [7:0]  remainder;
    logic [2:0]  phase;
    logic        slip_detected;
    logic [7:0]  needle_mask;
    sq_t         ai_from;
    sq_t         ai_to;
    logic        ai_valid;

    modport master (
        output step, player_move, player_from, player_to,
        input  remainder, phase, slip_detected, needle_mask, ai_from, ai_to, ai_valid
    );

    modport slave (
        input  step, player_move, player_from, player_to,
        output remainder, phase, slip_detected, needle_mask, ai_from, ai_to, ai_valid
    );

endinterface

// File: rtl/needle_res_scan.sv
// Combinational resistance scan: per-square neighbour sum, occupied-square argmin
// and (when NAND_NEEDLE_AI_EN is defined) empty-square argmax.
module needle_res_scan
    import nand_needle_pkg::*;
(
    input  board_t board,
    output res_t   min_res,
    output sq_t    argmin,
    output logic   any_occ
`ifdef NAND_NEEDLE_AI_EN
    ,
    output sq_t    argmax_empty,
    output logic   any_empty
`endif
);

    // Sum of the four orthogonal neighbour codes, no wrap at board edges.
    function automatic res_t res_of(input board_t b, input sq_t sq);
        res_t acc;
        acc = '0;
        if (file_of(sq) != 3'd0) acc = acc + 8'(b[sq - 6'd1]);
        if (file_of(sq) != 3'd7) acc = acc + 8'(b[sq + 6'd1]);
        if (rank_of(sq) != 3'd0) acc = acc + 8'(b[sq - 6'd8]);
        if (rank_of(sq) != 3'd7) acc = acc + 8'(b[sq + 6'd8]);
        return acc;
    endfunction

    // Single pass over all squares; strict compares keep the lowest index on ties.
    always_comb begin
        res_t res;
`ifdef NAND_NEEDLE_AI_EN
        res_t max_res;
        max_res      = '0;
        argmax_empty = '0;
        any_empty    = 1'b0;
`endif
        min_res = RES_NONE;
        argmin  = '0;
        any_occ = 1'b0;
        for (int i = 0; i < int'(NUM_SQ); i++) begin
            res = res_of(board, sq_t'(i));
            if (board[i] != EMPTY) begin
                if (!any_occ || (res < min_res)) begin
                    min_res = res;
                    argmin  = sq_t'(i);
                end
                any_occ = 1'b1;
            end
`ifdef NAND_NEEDLE_AI_EN
            else begin
                if (!any_empty || (res > max_res)) begin
                    max_res      = res;
                    argmax_empty = sq_t'(i);
                end
                any_empty = 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/nand_needle_8bit_core.sv
// NAND-needle board core: board storage, player moves, friction scan with NAND
// remainder fold, sticky slip flag and optional AI move suggestion.
// Optional feature macro: NAND_NEEDLE_AI_EN (AI suggestion search).
module nand_needle_8bit_core
    import nand_needle_pkg::*;
#(
    parameter int unsigned SLIP_THRESH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    nand_needle_8bit_core_if.slave        bus
);

    localparam logic [8:0] SLIP_LIM = 9'(SLIP_THRESH);

    board_t     board_q, board_d;
    res_t       remainder_q, remainder_d;
    logic [2:0] phase_q, phase_d;
    logic       slip_q, slip_d;
    logic [7:0] needle_mask_q, needle_mask_d;
    res_t       curr_min_res_q, curr_min_res_d;
    res_t       prev_min_res_q, prev_min_res_d;
    logic       first_scan_q, first_scan_d;

    // Scan-result registers kept under their architectural names for probing.
    res_t curr_min_res;
    res_t prev_min_res;
    assign curr_min_res = curr_min_res_q;
    assign prev_min_res = prev_min_res_q;

    logic unused_prev;
    assign unused_prev = ^prev_min_res;

    res_t scan_min;
    sq_t  scan_argmin;
    logic scan_any_occ;

`ifdef NAND_NEEDLE_AI_EN
    sq_t  scan_argmax;
    logic scan_any_empty;
    sq_t  ai_from_q, ai_from_d;
    sq_t  ai_to_q, ai_to_d;
    logic ai_valid_q, ai_valid_d;
`endif

    needle_res_scan u_scan (
        .board        (board_q),
        .min_res      (scan_min),
        .argmin       (scan_argmin),
        .any_occ      (scan_any_occ)
`ifdef NAND_NEEDLE_AI_EN
        ,
        .argmax_empty (scan_argmax),
        .any_empty    (scan_any_empty)
`endif
    );

    // Bench backdoor: read a square's code.
    function automatic piece_t get_piece(input sq_t sq);
        return board_q[sq];
    endfunction

    // Bench backdoor: overwrite a square's code.
    task automatic set_piece(input sq_t sq, input piece_t code);
        board_q[sq] <= code;
    endtask

    // Absolute difference of two 8-bit resistances.
    function automatic res_t abs_diff(input res_t a, input res_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Next-state: move commit and scan update, both from the pre-edge board.
    always_comb begin
        board_d        = board_q;
        remainder_d    = remainder_q;
        phase_d        = phase_q;
        slip_d         = slip_q;
        needle_mask_d  = needle_mask_q;
        curr_min_res_d = curr_min_res_q;
        prev_min_res_d = prev_min_res_q;
        first_scan_d   = first_scan_q;
`ifdef NAND_NEEDLE_AI_EN
        ai_from_d      = ai_from_q;
        ai_to_d        = ai_to_q;
        ai_valid_d     = 1'b0;
`endif

        if (bus.player_move && (bus.player_from != bus.player_to)) begin
            board_d[bus.player_to]   = board_q[bus.player_from];
            board_d[bus.player_from] = EMPTY;
        end

        if (bus.step) begin
            prev_min_res_d = curr_min_res_q;
            curr_min_res_d = scan_min;
            remainder_d    = ~(remainder_q & scan_min);
            phase_d        = phase_q + 3'd1;
            needle_mask_d  = scan_any_occ ? (8'd1 << file_of(scan_argmin)) : 8'h00;
            first_scan_d   = 1'b0;
            if (!first_scan_q && ({1'b0, abs_diff(scan_min, curr_min_res_q)} > SLIP_LIM)) begin
                slip_d = 1'b1;
            end
`ifdef NAND_NEEDLE_AI_EN
            ai_from_d  = scan_argmin;
            ai_to_d    = scan_argmax;
            ai_valid_d = scan_any_occ & scan_any_empty;
`endif
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_q        <= '0;
            remainder_q    <= '0;
            phase_q        <= '0;
            slip_q         <= 1'b0;
            needle_mask_q  <= '0;
            curr_min_res_q <= '0;
            prev_min_res_q <= '0;
            first_scan_q   <= 1'b1;
`ifdef NAND_NEEDLE_AI_EN
            ai_from_q      <= '0;
            ai_to_q        <= '0;
            ai_valid_q     <= 1'b0;
`endif
        end else begin
            board_q        <= board_d;
            remainder_q    <= remainder_d;
            phase_q        <= phase_d;
            slip_q         <= slip_d;
            needle_mask_q  <= needle_mask_d;
            curr_min_res_q <= curr_min_res_d;
            prev_min_res_q <= prev_min_res_d;
            first_scan_q   <= first_scan_d;
`ifdef NAND_NEEDLE_AI_EN
            ai_from_q      <= ai_from_d;
            ai_to_q        <= ai_to_d;
            ai_valid_q     <= ai_valid_d;
`endif
        end
    end

    assign bus.remainder     = remainder_q;
    assign bus.phase         = phase_q;
    assign bus.slip_detected = slip_q;
    assign bus.needle_mask   = needle_mask_q;
`ifdef NAND_NEEDLE_AI_EN
    assign bus.ai_from       = ai_from_q;
    assign bus.ai_to         = ai_to_q;
    assign bus.ai_valid      = ai_valid_q;
`else
    assign bus.ai_from       = '0;
    assign bus.ai_to         = '0;
    assign bus.ai_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_nand_needle_8bit_core.sv
// Directed self-checking bench for nand_needle_8bit_core.
module tb_nand_needle_8bit_core;
    import nand_needle_pkg::*;

`ifdef NAND_NEEDLE_AI_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    logic all_zero;

    nand_needle_8bit_core_if bus();

    nand_needle_8bit_core #(.SLIP_THRESH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus: drive at negedge, release and return #1 after posedge.
    task automatic cyc(input logic s, input logic m, input sq_t f, input sq_t t);
        @(negedge clk);
        bus.step        = s;
        bus.player_move = m;
        bus.player_from = f;
        bus.player_to   = t;
        @(posedge clk);
        #1;
        bus.step        = 1'b0;
        bus.player_move = 1'b0;
    endtask

    task automatic board_is_empty(output logic ok);
        ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (dut.get_piece(sq_t'(i)) != 4'd0) ok = 1'b0;
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.step        = 1'b0;
        bus.player_move = 1'b0;
        bus.player_from = '0;
        bus.player_to   = '0;

        // Reset state
        #12;
        chk("rst_remainder", 32'(bus.remainder), 32'h00);
        chk("rst_phase", 32'(bus.phase), 32'd0);
        chk("rst_slip", 32'(bus.slip_detected), 32'd0);
        chk("rst_needle", 32'(bus.needle_mask), 32'h00);
        chk("rst_ai_from", 32'(bus.ai_from), 32'd0);
        chk("rst_ai_to", 32'(bus.ai_to), 32'd0);
        chk("rst_ai_valid", 32'(bus.ai_valid), 32'd0);
        chk("rst_curr_min", 32'(dut.curr_min_res), 32'h00);
        chk("rst_prev_min", 32'(dut.prev_min_res), 32'h00);
        board_is_empty(all_zero);
        chk("rst_board", 32'(all_zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Scan 1: 1@27, 2@28 -> min 1 at 28 (file 4)
        dut.set_piece(6'd27, 4'd1);
        dut.set_piece(6'd28, 4'd2);
        cyc(1'b1, 1'b0, 6'd0, 6'd0);
        chk("s1_curr_min", 32'(dut.curr_min_res), 32'd1);
        chk("s1_prev_min", 32'(dut.prev_min_res), 32'd0);
        chk("s1_needle", 32'(bus.needle_mask), 32'h10);
        chk("s1_remainder", 32'(bus.remainder), 32'hFF);
        chk("s1_phase", 32'(bus.phase), 32'd1);
        chk("s1_slip", 32'(bus.slip_detected), 32'd0);
        chk("s1_ai_from", 32'(bus.ai_from), AI ? 32'd28 : 32'd0);
        chk("s1_ai_to", 32'(bus.ai_to), AI ? 32'd20 : 32'd0);
        chk("s1_ai_valid", 32'(bus.ai_valid), AI ? 32'd1 : 32'd0);
        cyc(1'b0, 1'b0, 6'd0, 6'd0);
        chk("s1_ai_valid_drop", 32'(bus.ai_valid), 32'd0);
        chk("s1_ai_from_hold", 32'(bus.ai_from), AI ? 32'd28 : 32'd0);

        // Scan 2: empty board -> min 0xFF, delta 254 sets slip
        dut.set_piece(6'd27, 4'd0);
        dut.set_piece(6'd28, 4'd0);
        cyc(1'b1, 1'b0, 6'd0, 6'd0);
        chk("s2_curr_min", 32'(dut.curr_min_res), 32'hFF);
        chk("s2_prev_min", 32'(dut.prev_min_res), 32'd1);
        chk("s2_needle", 32'(bus.needle_mask), 32'h00);
        chk("s2_remainder", 32'(bus.remainder), 32'h00);
        chk("s2_phase", 32'(bus.phase), 32'd2);
        chk("s2_slip", 32'(bus.slip_detected), 32'd1);
        chk("s2_ai_valid", 32'(bus.ai_valid), 32'd0);

        // Quiet scans keep slip sticky
        cyc(1'b1, 1'b0, 6'd0, 6'd0);
        chk("s3_remainder", 32'(bus.remainder), 32'hFF);
        cyc(1'b1, 1'b0, 6'd0, 6'd0);
        chk("s4_remainder", 32'(bus.remainder), 32'h00);
        chk("s4_phase", 32'(bus.phase), 32'd4);
        chk("s4_slip_sticky", 32'(bus.slip_detected), 32'd1);

        // Player move 12 -> 28
        dut.set_piece(6'd12, 4'd1);
        cyc(1'b0, 1'b1, 6'd12, 6'd28);
        chk("mv_to", 32'(dut.get_piece(6'd28)), 32'd1);
        chk("mv_from", 32'(dut.get_piece(6'd12)), 32'd0);
        chk("mv_phase_idle", 32'(bus.phase), 32'd4);

        // Same-square move leaves board unchanged
        cyc(1'b0, 1'b1, 6'd28, 6'd28);
        chk("mv_same_sq", 32'(dut.get_piece(6'd28)), 32'd1);

        // Scan 5 with simultaneous move 28 -> 15: scan sees 1@28, 3@36
        dut.set_piece(6'd36, 4'd3);
        cyc(1'b1, 1'b1, 6'd28, 6'd15);
        chk("s5_curr_min", 32'(dut.curr_min_res), 32'd1);
        chk("s5_needle", 32'(bus.needle_mask), 32'h10);
        chk("s5_remainder", 32'(bus.remainder), 32'hFF);
        chk("s5_phase", 32'(bus.phase), 32'd5);
        chk("s5_ai_from", 32'(bus.ai_from), AI ? 32'd36 : 32'd0);
        chk("s5_ai_to", 32'(bus.ai_to), AI ? 32'd35 : 32'd0);
        chk("s5_moved_to", 32'(dut.get_piece(6'd15)), 32'd1);
        chk("s5_moved_from", 32'(dut.get_piece(6'd28)), 32'd0);

        // Scan 6 reflects the move: min 0 at 15 (file 7)
        cyc(1'b1, 1'b0, 6'd0, 6'd0);
        chk("s6_curr_min", 32'(dut.curr_min_res), 32'd0);
        chk("s6_prev_min", 32'(dut.prev_min_res), 32'd1);
        chk("s6_needle", 32'(bus.needle_mask), 32'h80);
        chk("s6_remainder", 32'(bus.remainder), 32'hFF);
        chk("s6_phase", 32'(bus.phase), 32'd6);
        chk("s6_ai_from", 32'(bus.ai_from), AI ? 32'd15 : 32'd0);
        chk("s6_ai_to", 32'(bus.ai_to), AI ? 32'd28 : 32'd0);

        // Asynchronous reset mid-operation, between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_remainder", 32'(bus.remainder), 32'h00);
        chk("arst_phase", 32'(bus.phase), 32'd0);
        chk("arst_slip", 32'(bus.slip_detected), 32'd0);
        chk("arst_needle", 32'(bus.needle_mask), 32'h00);
        chk("arst_curr_min", 32'(dut.curr_min_res), 32'h00);
        board_is_empty(all_zero);
        chk("arst_board", 32'(all_zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Nine scans on 5@0, 3@1: min 3 at square 0, remainder alternates FF/FC
        dut.set_piece(6'd0, 4'd5);
        dut.set_piece(6'd1, 4'd3);
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b1, 1'b0, 6'd0, 6'd0);
            chk("nine_remainder", 32'(bus.remainder), (k % 2 == 1) ? 32'hFF : 32'hFC);
            chk("nine_phase", 32'(bus.phase), 32'(k % 8));
            chk("nine_ai_valid", 32'(bus.ai_valid), AI ? 32'd1 : 32'd0);
        end
        chk("nine_curr_min", 32'(dut.curr_min_res), 32'd3);
        chk("nine_needle", 32'(bus.needle_mask), 32'h01);
        chk("nine_slip", 32'(bus.slip_detected), 32'd0);
        chk("nine_ai_from", 32'(bus.ai_from), 32'd0);
        chk("nine_ai_to", 32'(bus.ai_to), AI ? 32'd8 : 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
